// File: rtl/pipe_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_share_arbiter
//  Purpose  : Shares one fixed-latency pipeline among N_REQ requesters.
//             A round-robin arbiter accepts at most one request per cycle and
//             registers the operand into the pipeline. A tag shift register
//             remembers which requester owns each in-flight operation, and
//             results are steered back to the owner when they emerge.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             hold                - blocks new grants; in-flight work drains
//             req_vld/req_data    - per-requester request and operand
//             req_rdy             - one-hot-or-zero grant (combinational)
//             pipe_in_vld/_data   - registered issue into the shared pipeline
//             pipe_out_vld/_data  - results from the shared pipeline
//             rsp_vld/rsp_data    - one-hot response strobe, shared data
//             busy                - any accepted request still outstanding
//             err                 - sticky tag/result alignment error
//  Revision : 1.0  initial release
// ============================================================================
module pipe_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int LAT   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hold,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   pipe_in_vld,
  output logic [WIDTH-1:0]       pipe_in_data,
  input  logic                   pipe_out_vld,
  input  logic [WIDTH-1:0]       pipe_out_data,
  output logic [N_REQ-1:0]       rsp_vld,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy,
  output logic                   err
);

  localparam int PTR_W = $clog2(N_REQ);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0] r_ptr;
  logic             r_pipe_in_vld;
  logic [WIDTH-1:0] r_pipe_in_data;
  logic [LAT:0]     r_tag_vld;
  logic [PTR_W-1:0] r_tag_idx [0:LAT];
  logic             r_err;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic             w_found;
  logic [PTR_W-1:0] w_grant_idx;
  logic [PTR_W:0]   w_sum;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_req_arr [N_REQ];

  // Unpack the flat operand bus into one slice per requester.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign w_req_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin search starting at r_ptr. The candidate index is formed one
  // bit wider than the pointer so the wrap can be done with a single compare
  // and subtract, which also handles non-power-of-two N_REQ.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    for (int off = 0; off < N_REQ; off++) begin
      w_sum = {1'b0, r_ptr} + (PTR_W+1)'(off);
      if (w_sum >= (PTR_W+1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W+1)'(N_REQ);
      end
      if (!w_found && req_vld[w_sum[PTR_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_sum[PTR_W-1:0];
      end
    end
    // Reset gating keeps the grant quiet while the block is held in reset,
    // even if requesters are already raising valid.
    if (hold || !rst_n) begin
      w_found = 1'b0;
    end
  end

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rdy
      assign req_rdy[gi] = w_found && (w_grant_idx == PTR_W'(gi));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pointer, issue register, tag pipeline and error flag
  // --------------------------------------------------------------------------
  // Tag stage 0 is loaded on the same edge as the issue register, so stage 0
  // always mirrors pipe_in_vld and stage LAT lines up with the pipeline
  // result LAT cycles after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr          <= '0;
      r_pipe_in_vld  <= 1'b0;
      r_pipe_in_data <= '0;
      r_tag_vld      <= '0;
      for (int i = 0; i <= LAT; i++) begin
        r_tag_idx[i] <= '0;
      end
      r_err          <= 1'b0;
    end else begin
      if (w_found) begin
        r_ptr          <= (w_grant_idx == PTR_W'(N_REQ-1)) ? '0
                                                           : w_grant_idx + PTR_W'(1);
        r_pipe_in_data <= w_req_arr[w_grant_idx];
      end
      r_pipe_in_vld <= w_found;
      r_tag_vld     <= {r_tag_vld[LAT-1:0], w_found};
      r_tag_idx[0]  <= w_grant_idx;
      for (int i = 1; i <= LAT; i++) begin
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
      if (w_mismatch) begin
        r_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response steering
  // --------------------------------------------------------------------------
  // A result without a tag, or a tag without a result, is an alignment error.
  // Both cases leave rsp_vld low because the strobe needs both to be present.
  assign w_mismatch = pipe_out_vld ^ r_tag_vld[LAT];

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rsp
      assign rsp_vld[gi] = pipe_out_vld && r_tag_vld[LAT] &&
                           (r_tag_idx[LAT] == PTR_W'(gi));
    end
  endgenerate

  assign rsp_data     = pipe_out_data;
  assign pipe_in_vld  = r_pipe_in_vld;
  assign pipe_in_data = r_pipe_in_data;
  assign busy         = r_pipe_in_vld | (|r_tag_vld);
  assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_share_arbiter
//  Purpose  : Directed self-checking bench for pipe_share_arbiter with
//             N_REQ=4, WIDTH=32, LAT=4 and a model pipeline that returns
//             operand+1 exactly four cycles after issue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_share_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int LAT   = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   hold;
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_rdy;
  logic                   pipe_in_vld;
  logic [WIDTH-1:0]       pipe_in_data;
  logic                   pipe_out_vld;
  logic [WIDTH-1:0]       pipe_out_data;
  logic [N_REQ-1:0]       rsp_vld;
  logic [WIDTH-1:0]       rsp_data;
  logic                   busy;
  logic                   err;

  logic                   inject;
  logic [LAT-1:0]         mp_vld = '0;
  logic [WIDTH-1:0]       mp_dat [LAT] = '{default: '0};

  int checks = 0;
  int errors = 0;

  pipe_share_arbiter #(
    .N_REQ (N_REQ),
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hold          (hold),
    .req_vld       (req_vld),
    .req_data      (req_data),
    .req_rdy       (req_rdy),
    .pipe_in_vld   (pipe_in_vld),
    .pipe_in_data  (pipe_in_data),
    .pipe_out_vld  (pipe_out_vld),
    .pipe_out_data (pipe_out_data),
    .rsp_vld       (rsp_vld),
    .rsp_data      (rsp_data),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model pipeline: not reset, so results issued before a reset still emerge.
  always @(posedge clk) begin
    mp_vld    <= {mp_vld[LAT-2:0], pipe_in_vld};
    mp_dat[0] <= pipe_in_data + 32'd1;
    for (int i = 1; i < LAT; i++) begin
      mp_dat[i] <= mp_dat[i-1];
    end
  end
  assign pipe_out_vld  = mp_vld[LAT-1] | inject;
  assign pipe_out_data = mp_dat[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_d(input int i, input logic [31:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b1;
    hold    = 1'b0;
    inject  = 1'b0;
    req_vld = 4'hF;
    req_data = '0;
    for (int i = 0; i < N_REQ; i++) set_d(i, 32'h100 + i);
    #1 rst_n = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick(); settle();
    chk("rst_rdy",   req_rdy,      0);
    chk("rst_rsp",   rsp_vld,      0);
    chk("rst_busy",  busy,         0);
    chk("rst_err",   err,          0);
    chk("rst_pvld",  pipe_in_vld,  0);
    chk("rst_pdata", pipe_in_data, 0);

    // ---------------- all four requesters valid ----------------
    for (int c = 0; c <= 10; c++) begin
      tick();
      if (c == 0) rst_n = 1'b1;
      if (c == 5) req_vld = 4'h0;
      settle();
      chk("rr_rdy", req_rdy, (c < 5) ? (1 << (c % 4)) : 0);
      if (c >= 1 && c <= 5) begin
        chk("rr_pvld",  pipe_in_vld, 1);
        chk("rr_pdata", pipe_in_data, 32'h100 + ((c - 1) % 4));
      end
      if (c >= 5 && c <= 9) begin
        chk("rr_rsp",  rsp_vld, 1 << ((c - 5) % 4));
        chk("rr_rdat", rsp_data, 32'h101 + ((c - 5) % 4));
      end else begin
        chk("rr_rsp0", rsp_vld, 0);
      end
      if (c == 1)  chk("rr_busy1", busy, 1);
      if (c == 10) chk("rr_busy0", busy, 0);
    end
    chk("rr_err", err, 0);

    // ---------------- single requester 2 streaming ----------------
    for (int d = 0; d <= 8; d++) begin
      tick();
      if (d < 3) begin
        req_vld = 4'b0100;
        set_d(2, 32'd10 + d);
      end else begin
        req_vld = 4'b0000;
      end
      settle();
      chk("s2_rdy", req_rdy, (d < 3) ? 4'b0100 : 4'b0000);
      if (d >= 1 && d <= 3) begin
        chk("s2_pvld",  pipe_in_vld, 1);
        chk("s2_pdata", pipe_in_data, 32'd9 + d);
      end
      if (d == 4) begin
        chk("s2_pvld0",  pipe_in_vld, 0);
        chk("s2_phold",  pipe_in_data, 32'd12);
      end
      if (d >= 5 && d <= 7) begin
        chk("s2_rsp",  rsp_vld, 4'b0100);
        chk("s2_rdat", rsp_data, 32'd6 + d);
      end
      if (d == 3) chk("s2_ptr", dut.r_ptr, 3);
    end

    // ---------------- hold blocks grants ----------------
    set_d(3, 32'h55);
    for (int h = 0; h <= 4; h++) begin
      tick();
      hold    = 1'b1;
      req_vld = 4'hF;
      settle();
      chk("hold_rdy", req_rdy, 0);
      if (h == 1) chk("hold_pvld", pipe_in_vld, 0);
      if (h == 4) chk("hold_busy", busy, 0);
    end
    tick();
    hold = 1'b0;
    settle();
    chk("unhold_rdy", req_rdy, 4'b1000);
    for (int h = 6; h <= 11; h++) begin
      tick();
      req_vld = 4'h0;
      settle();
      if (h == 6) begin
        chk("unhold_pvld",  pipe_in_vld, 1);
        chk("unhold_pdata", pipe_in_data, 32'h55);
      end
      if (h == 10) begin
        chk("unhold_rsp",  rsp_vld, 4'b1000);
        chk("unhold_rdat", rsp_data, 32'h56);
      end
      if (h == 11) chk("unhold_busy", busy, 0);
    end
    chk("unhold_ptr", dut.r_ptr, 0);

    // ---------------- spurious result ----------------
    tick();
    inject = 1'b1;
    settle();
    chk("spur_rsp",  rsp_vld, 0);
    chk("spur_err0", err, 0);
    tick();
    inject = 1'b0;
    settle();
    chk("spur_err1", err, 1);
    chk("spur_rsp1", rsp_vld, 0);
    tick(); settle();
    chk("spur_sticky", err, 1);

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 3; i++) set_d(i, 32'h200 + i);
    for (int f = 0; f <= 2; f++) begin
      tick();
      req_vld = 4'b0111;
      settle();
      chk("mr_rdy", req_rdy, 1 << f);
    end
    tick();
    req_vld = 4'b0000;
    tick();
    rst_n   = 1'b0;
    req_vld = 4'b1001;
    settle();
    chk("mr_rst_rdy",   req_rdy, 0);
    chk("mr_rst_busy",  busy, 0);
    chk("mr_rst_err",   err, 0);
    chk("mr_rst_pvld",  pipe_in_vld, 0);
    chk("mr_rst_pdata", pipe_in_data, 0);
    chk("mr_rst_rsp",   rsp_vld, 0);
    tick(); settle();
    chk("mr_rst_rsp2",  rsp_vld, 0);
    chk("mr_rst_err2",  err, 0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("mr_rel_rdy",  req_rdy, 4'b0001);
    chk("mr_rel_err",  err, 0);
    tick();
    req_vld = 4'b0000;
    settle();
    chk("mr_late_err", err, 1);
    chk("mr_late_rsp", rsp_vld, 0);
    tick(); tick(); tick(); tick();
    settle();
    chk("mr_new_rsp",  rsp_vld, 4'b0001);
    chk("mr_new_rdat", rsp_data, 32'h201);
    chk("mr_new_err",  err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
